countdown_timer: RTL

- Down-counting H:M:S timer; the decrementing counterpart to the free-running up-counting time-of-day clock.
- Loaded with a start time from the user-input/set logic. Counts down once per second.
- Pulses `done` on reaching 00:00:00.
- Outputs use the same 8-bit seconds/minutes/hours encoding as the time-of-day clock, so the display path is shared.

---
 rtl/countdown_timer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// H:M:S countdown timer with LOAD/START/PAUSE control and a one-cycle done pulse at 00:00:00.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the last accepted LOAD value on expiry and keep running.
module countdown_timer #(
    parameter int CLOCK_FREQ = 50000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LOAD,
    input  logic [7:0] load_seconds,
    input  logic [7:0] load_minutes,
    input  logic [7:0] load_hours,
    input  logic       START,
    input  logic       PAUSE,
    output logic [7:0] seconds,
    output logic [7:0] minutes,
    output logic [7:0] hours,
    output logic       running,
    output logic       expired,
    output logic       done,
    output logic       load_err
);

    localparam int PW = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(CLOCK_FREQ - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSED  = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    logic [1:0]    state;
    logic [PW-1:0] presc;
    logic          load_ok;
    logic          tick;
    logic [23:0]   dec_next;
    logic          at_zero;
    logic          time_nz;
    logic [23:0]   reload_hms;
    logic          reload_en;

    // Borrow chain: seconds first, then minutes, then hours; never goes below 00:00:00.
    function automatic logic [23:0] dec_hms(input logic [7:0] h, input logic [7:0] m,
                                            input logic [7:0] s);
        if (s != 8'd0)
            return {h, m, s - 8'd1};
        else if (m != 8'd0)
            return {h, m - 8'd1, 8'd59};
        else if (h != 8'd0)
            return {h - 8'd1, 8'd59, 8'd59};
        else
            return 24'd0;
    endfunction

    assign load_ok  = (load_seconds < 8'd60) && (load_minutes < 8'd60) && (load_hours < 8'd24);
    assign tick     = (state == S_RUN) && (presc == PRESC_TC);
    assign dec_next = dec_hms(hours, minutes, seconds);
    assign at_zero  = (dec_next == 24'd0);
    assign time_nz  = |{hours, minutes, seconds};
    assign running  = (state == S_RUN);
    assign expired  = (state == S_EXPIRED);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    always_ff @(posedge CLK) begin
        if (RST)
            reload_hms <= 24'd0;
        else if (LOAD && load_ok)
            reload_hms <= {load_hours, load_minutes, load_seconds};
    end
    assign reload_en = (reload_hms != 24'd0);
`else
    assign reload_hms = 24'd0;
    assign reload_en  = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            presc    <= '0;
            seconds  <= 8'd0;
            minutes  <= 8'd0;
            hours    <= 8'd0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            done     <= 1'b0;
            load_err <= 1'b0;
            if (LOAD) begin
                // A rejected load freezes the whole timer for that cycle.
                if (load_ok) begin
                    {hours, minutes, seconds} <= {load_hours, load_minutes, load_seconds};
                    presc <= '0;
                    state <= S_IDLE;
                end else begin
                    load_err <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (START && time_nz) begin
                            state <= S_RUN;
                            presc <= '0;
                        end
                    end
                    S_RUN: begin
                        // PAUSE beats a coincident tick; the prescaler stays at terminal count.
                        if (PAUSE) begin
                            state <= S_PAUSED;
                        end else if (tick) begin
                            presc <= '0;
                            if (at_zero && reload_en) begin
                                {hours, minutes, seconds} <= reload_hms;
                                done <= 1'b1;
                            end else begin
                                {hours, minutes, seconds} <= dec_next;
                                if (at_zero) begin
                                    done  <= 1'b1;
                                    state <= S_EXPIRED;
                                end
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    S_PAUSED: begin
                        if (START)
                            state <= S_RUN;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
